damage_accumulator: RTL and testbench
=====================================

DAMAGE_ACCUMULATOR -- requirements
Module: damage_accumulator

Interface
REQ-001 Parameter NUM_PLAYERS, default 4, number of per-player damage counters (2..8).
REQ-002 Parameter DMG_W, default 10, width of each damage counter.
REQ-003 Parameter MAX_DMG, default 999, saturation ceiling for each counter.
REQ-004 Parameter INVULN_CYCLES, default 60, post-hit invulnerability length in clock cycles (1..255).
REQ-005 Port clock  in  1  single clock; all state updates on its falling edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port atk_valid  in  1  attack request this cycle.
REQ-008 Port attack  in  32  attack word (bit0 = hit qualifier, bits5..10 = move flags).
REQ-009 Port atk_target  in  3  target player index.
REQ-010 Port atk_ready  out  1  attack may be accepted this cycle.
REQ-011 Port ko_valid / ko_player  in  1 / 3  KO strobe and player to clear.
REQ-012 Port damage_bus  out  NUM_PLAYERS*DMG_W  packed counters, player 0 in LSBs.
REQ-013 Port last_damage  out  DMG_W  amount added by most recent applied hit.
REQ-014 Port hit_ack / atk_drop  out  1 / 1  one-cycle pulses: hit applied / request rejected.
REQ-015 Port invuln  out  NUM_PLAYERS  per-player invulnerable flags.

Function
REQ-016 Base damage decode SHALL be, first match wins: bit0&bit5=5, bit0&bit6=20, bit0&bit7=15, bit0&(bit8|bit9)=30, bit0&bit10=10, else 0; move class = matching row index 0..4.
REQ-017 atk_ready SHALL equal ~ko_valid; a request is offered when atk_valid & atk_ready.
REQ-018 An offered request SHALL be accepted only if base != 0, atk_target < NUM_PLAYERS and invuln[atk_target] = 0; otherwise atk_drop pulses the following cycle and no state changes.
REQ-019 Acceptance edge (stage 1) SHALL register target, class and applied amount and load the target's invulnerability counter with INVULN_CYCLES.
REQ-020 Next edge (stage 2) SHALL add the applied amount to the target counter, saturating at MAX_DMG, set last_damage, and pulse hit_ack for one cycle; total latency 2 edges.
REQ-021 A request accepted in the cycle after another SHALL be pipelined with no bubble; a second hit on the same target is blocked by REQ-018.
REQ-022 invuln[i] SHALL be 1 while counter i is nonzero; nonzero counters decrement by 1 each edge not loaded.
REQ-023 ko_valid SHALL, on that edge, zero the counter, invulnerability counter and stale history of ko_player; ko_player >= NUM_PLAYERS is ignored.
REQ-024 If stage 2 targets ko_player on the KO edge, KO SHALL win: no add, no hit_ack, atk_drop pulses.
REQ-025 Sum exceeding MAX_DMG SHALL clamp to MAX_DMG; counters SHALL never wrap.

Reset
REQ-026 reset SHALL asynchronously zero all counters, invulnerability counters, pipeline registers, stale history, last_damage, hit_ack and atk_drop.
REQ-027 A request in stage 1 when reset asserts SHALL be discarded without hit_ack.

Configuration
REQ-028 Macro DAMAGE_STALE_MOVES_EN defined: per-target last-accepted class is stored; a hit repeating it SHALL apply floor(base/2).
REQ-029 Macro DAMAGE_STALE_MOVES_EN undefined: no history storage; applied amount SHALL always equal base.

Verification
REQ-030 Reset, then attack=0x021 to player 1 -> hit_ack 2 edges later, player 1 counter=5, last_damage=5, invuln[1]=1 for 60 cycles.
REQ-031 Player 2 hit with 0x041, second 0x041 one cycle later -> counter=20, second request atk_drop.
REQ-032 Player 0 preloaded to 990, attack 0x101 -> counter=999, last_damage=30.
REQ-033 ko_valid for player 3 on stage-2 edge of its hit -> counter 0, no hit_ack, atk_drop pulses, atk_ready low that cycle.
REQ-034 With DAMAGE_STALE_MOVES_EN, 0x081 to player 1 twice, 61 cycles apart -> counter 15 then 22; without macro -> 15 then 30.

Source files
------------

// File: rtl/damage_accumulator_if.sv
// Attack request/response channel of damage_accumulator.
// The slave side (the accumulator) takes requests and returns ready, ack, drop and the last amount applied.
interface damage_accumulator_if #(
  parameter int DMG_W = 10
);
  logic             atk_valid;
  logic [31:0]      attack;
  logic [2:0]       atk_target;
  logic             atk_ready;
  logic             hit_ack;
  logic             atk_drop;
  logic [DMG_W-1:0] last_damage;

  modport slave (
    input  atk_valid, attack, atk_target,
    output atk_ready, hit_ack, atk_drop, last_damage
  );

  modport master (
    output atk_valid, attack, atk_target,
    input  atk_ready, hit_ack, atk_drop, last_damage
  );
endinterface

// File: rtl/damage_accumulator.sv
// Per-player damage counters fed by a two-stage hit pipeline, with invulnerability windows and KO clearing.
// Optional macro DAMAGE_STALE_MOVES_EN halves a hit that repeats the target's last accepted move class.
module damage_accumulator #(
  parameter int NUM_PLAYERS   = 4,
  parameter int DMG_W         = 10,
  parameter int MAX_DMG       = 999,
  parameter int INVULN_CYCLES = 60
) (
  input  logic                         clock,
  input  logic                         reset,
  damage_accumulator_if.slave          atk_if,
  input  logic                         ko_valid,
  input  logic [2:0]                   ko_player,
  output logic [NUM_PLAYERS*DMG_W-1:0] damage_bus,
  output logic [NUM_PLAYERS-1:0]       invuln
);

  localparam logic [3:0]       NP       = 4'(NUM_PLAYERS);
  localparam logic [DMG_W-1:0] MAX_V    = DMG_W'(MAX_DMG);
  localparam logic [7:0]       INV_LOAD = 8'(INVULN_CYCLES);

  function automatic logic [5:0] base_of(input logic [31:0] a);
    if (!a[0])            return 6'd0;
    else if (a[5])        return 6'd5;
    else if (a[6])        return 6'd20;
    else if (a[7])        return 6'd15;
    else if (a[8] | a[9]) return 6'd30;
    else if (a[10])       return 6'd10;
    else                  return 6'd0;
  endfunction

`ifdef DAMAGE_STALE_MOVES_EN
  function automatic logic [2:0] class_of(input logic [31:0] a);
    if (a[5])             return 3'd0;
    else if (a[6])        return 3'd1;
    else if (a[7])        return 3'd2;
    else if (a[8] | a[9]) return 3'd3;
    else                  return 3'd4;
  endfunction
`endif

  function automatic logic [DMG_W-1:0] sat_add(input logic [DMG_W-1:0] cur,
                                               input logic [DMG_W-1:0] amt);
    logic [DMG_W:0] sum;
    sum = {1'b0, cur} + {1'b0, amt};
    if (sum > {1'b0, MAX_V}) return MAX_V;
    return sum[DMG_W-1:0];
  endfunction

  logic [DMG_W-1:0] dmg_q [NUM_PLAYERS];
  logic [DMG_W-1:0] dmg_d [NUM_PLAYERS];
  logic [7:0]       inv_q [NUM_PLAYERS];
  logic [7:0]       inv_d [NUM_PLAYERS];
  logic             vld_p1_q, vld_p1_d;
  logic [2:0]       tgt_p1_q, tgt_p1_d;
  logic [DMG_W-1:0] amt_p1_q, amt_p1_d;
  logic             hit_ack_q, hit_ack_d;
  logic             atk_drop_q, atk_drop_d;
  logic [DMG_W-1:0] last_damage_q, last_damage_d;
`ifdef DAMAGE_STALE_MOVES_EN
  logic             hist_vld_q [NUM_PLAYERS];
  logic             hist_vld_d [NUM_PLAYERS];
  logic [2:0]       hist_cls_q [NUM_PLAYERS];
  logic [2:0]       hist_cls_d [NUM_PLAYERS];
  logic [2:0]       cls;
`endif

  logic       offered, accept, kill, ko_ok, tgt_ok, tgt_inv, stale;
  logic [5:0] base;
  logic [DMG_W-1:0] amt;
  logic       unused_attack_bits;

  assign atk_if.atk_ready   = ~ko_valid;
  assign atk_if.hit_ack     = hit_ack_q;
  assign atk_if.atk_drop    = atk_drop_q;
  assign atk_if.last_damage = last_damage_q;
  assign unused_attack_bits = ^{atk_if.attack[31:11], atk_if.attack[4:1]};

  // Stage 0: decode and qualify the offered request
  always_comb begin
    offered = atk_if.atk_valid & atk_if.atk_ready;
    base    = base_of(atk_if.attack);
    tgt_ok  = {1'b0, atk_if.atk_target} < NP;
    ko_ok   = ko_valid & ({1'b0, ko_player} < NP);
    tgt_inv = 1'b1;
    stale   = 1'b0;
`ifdef DAMAGE_STALE_MOVES_EN
    cls     = class_of(atk_if.attack);
`endif
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (atk_if.atk_target == 3'(i)) begin
        tgt_inv = (inv_q[i] != 8'd0);
`ifdef DAMAGE_STALE_MOVES_EN
        stale   = hist_vld_q[i] && (hist_cls_q[i] == cls);
`endif
      end
    end
    amt    = stale ? DMG_W'(base >> 1) : DMG_W'(base);
    accept = offered & (base != 6'd0) & tgt_ok & ~tgt_inv;
    // KO on the add edge of the same player cancels the add and reports it as dropped
    kill   = vld_p1_q & ko_ok & (ko_player == tgt_p1_q);
  end

  // Stage 1 capture and stage 2 accumulate
  always_comb begin
    vld_p1_d      = accept;
    tgt_p1_d      = accept ? atk_if.atk_target : tgt_p1_q;
    amt_p1_d      = accept ? amt : amt_p1_q;
    hit_ack_d     = vld_p1_q & ~kill;
    atk_drop_d    = (offered & ~accept) | kill;
    last_damage_d = hit_ack_d ? amt_p1_q : last_damage_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      dmg_d[i] = dmg_q[i];
      inv_d[i] = (inv_q[i] != 8'd0) ? inv_q[i] - 8'd1 : 8'd0;
`ifdef DAMAGE_STALE_MOVES_EN
      hist_vld_d[i] = hist_vld_q[i];
      hist_cls_d[i] = hist_cls_q[i];
      if (accept && atk_if.atk_target == 3'(i)) begin
        hist_vld_d[i] = 1'b1;
        hist_cls_d[i] = cls;
      end
`endif
      if (hit_ack_d && tgt_p1_q == 3'(i)) dmg_d[i] = sat_add(dmg_q[i], amt_p1_q);
      if (accept && atk_if.atk_target == 3'(i)) inv_d[i] = INV_LOAD;
      if (ko_ok && ko_player == 3'(i)) begin
        dmg_d[i] = '0;
        inv_d[i] = 8'd0;
`ifdef DAMAGE_STALE_MOVES_EN
        hist_vld_d[i] = 1'b0;
        hist_cls_d[i] = 3'd0;
`endif
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      vld_p1_q      <= 1'b0;
      tgt_p1_q      <= 3'd0;
      amt_p1_q      <= '0;
      hit_ack_q     <= 1'b0;
      atk_drop_q    <= 1'b0;
      last_damage_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        dmg_q[i] <= '0;
        inv_q[i] <= 8'd0;
`ifdef DAMAGE_STALE_MOVES_EN
        hist_vld_q[i] <= 1'b0;
        hist_cls_q[i] <= 3'd0;
`endif
      end
    end else begin
      vld_p1_q      <= vld_p1_d;
      tgt_p1_q      <= tgt_p1_d;
      amt_p1_q      <= amt_p1_d;
      hit_ack_q     <= hit_ack_d;
      atk_drop_q    <= atk_drop_d;
      last_damage_q <= last_damage_d;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        dmg_q[i] <= dmg_d[i];
        inv_q[i] <= inv_d[i];
`ifdef DAMAGE_STALE_MOVES_EN
        hist_vld_q[i] <= hist_vld_d[i];
        hist_cls_q[i] <= hist_cls_d[i];
`endif
      end
    end
  end

  always_comb begin
    damage_bus = '0;
    invuln     = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      damage_bus[i*DMG_W +: DMG_W] = dmg_q[i];
      invuln[i] = (inv_q[i] != 8'd0);
    end
  end

endmodule

// File: tb/tb_damage_accumulator.sv
// Scoreboard bench for damage_accumulator: expected acks/drops are queued with the edge they are due on.
module tb_damage_accumulator;

  localparam int NP = 4;
  localparam int DW = 10;

  logic              clock = 1'b1;
  logic              reset;
  logic              ko_valid;
  logic [2:0]        ko_player;
  logic [NP*DW-1:0]  damage_bus;
  logic [NP-1:0]     invuln;

  damage_accumulator_if #(.DMG_W(DW)) aif ();

  damage_accumulator #(.NUM_PLAYERS(NP), .DMG_W(DW), .MAX_DMG(999), .INVULN_CYCLES(60)) dut (
    .clock      (clock),
    .reset      (reset),
    .atk_if     (aif.slave),
    .ko_valid   (ko_valid),
    .ko_player  (ko_player),
    .damage_bus (damage_bus),
    .invuln     (invuln)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(negedge clock) cyc <= cyc + 1;

  typedef struct {
    bit hit;
    int tgt;
    int amt;
    int total;
    int due;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  int  exp_dmg [8];
  bit  hit_seen[8];
  int  acc_edge[8];
  bit  hist_v  [8];
  int  hist_c  [8];

  function automatic int base_of(input logic [31:0] a);
    if (!a[0]) return 0;
    if (a[5]) return 5;
    if (a[6]) return 20;
    if (a[7]) return 15;
    if (a[8] || a[9]) return 30;
    if (a[10]) return 10;
    return 0;
  endfunction

  function automatic int class_of(input logic [31:0] a);
    if (a[5]) return 0;
    if (a[6]) return 1;
    if (a[7]) return 2;
    if (a[8] || a[9]) return 3;
    return 4;
  endfunction

  function automatic int dmg_of(input int p);
    return int'(damage_bus[p*DW +: DW]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      exp_dmg[i] = 0; hit_seen[i] = 0; acc_edge[i] = 0; hist_v[i] = 0; hist_c[i] = 0;
    end
  endtask

  // One falling edge; then score everything due on it
  task automatic tick();
    ev_t e;
    bit  ea, ed;
    @(posedge clock);
    ea = 0; ed = 0;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.hit) begin
        ea = 1;
        n_checks++;
        if (int'(aif.last_damage) != e.amt) begin
          n_errors++;
          $display("FAIL last_damage p%0d: got %0d want %0d", e.tgt, aif.last_damage, e.amt);
        end
        n_checks++;
        if (dmg_of(e.tgt) != e.total) begin
          n_errors++;
          $display("FAIL counter p%0d: got %0d want %0d", e.tgt, dmg_of(e.tgt), e.total);
        end
      end else begin
        ed = 1;
      end
    end
    n_checks++;
    if (aif.hit_ack !== ea) begin
      n_errors++;
      $display("FAIL hit_ack edge %0d: got %b want %b", cyc, aif.hit_ack, ea);
    end
    n_checks++;
    if (aif.atk_drop !== ed) begin
      n_errors++;
      $display("FAIL atk_drop edge %0d: got %b want %b", cyc, aif.atk_drop, ed);
    end
  endtask

  task automatic offer(input logic [31:0] word, input int tgt);
    int  e, base, amt;
    bit  ok;
    ev_t ev;
    e    = cyc + 1;
    base = base_of(word);
    ok   = (base != 0) && (tgt < NP) && !(hit_seen[tgt] && (e - acc_edge[tgt] <= 60));
    amt  = base;
`ifdef DAMAGE_STALE_MOVES_EN
    if (hist_v[tgt] && hist_c[tgt] == class_of(word)) amt = base / 2;
`endif
    if (ok) begin
      exp_dmg[tgt] = (exp_dmg[tgt] + amt > 999) ? 999 : exp_dmg[tgt] + amt;
      hit_seen[tgt] = 1; acc_edge[tgt] = e;
      hist_v[tgt] = 1; hist_c[tgt] = class_of(word);
      ev.hit = 1; ev.tgt = tgt; ev.amt = amt; ev.total = exp_dmg[tgt]; ev.due = e + 1;
    end else begin
      ev.hit = 0; ev.tgt = tgt; ev.amt = 0; ev.total = 0; ev.due = e;
    end
    sb.push_back(ev);
    aif.atk_valid = 1'b1; aif.attack = word; aif.atk_target = 3'(tgt);
    tick();
    aif.atk_valid = 1'b0; aif.attack = '0;
  endtask

  task automatic ko(input int p);
    int e;
    e = cyc + 1;
    if (p < NP) begin
      exp_dmg[p] = 0; hit_seen[p] = 0; hist_v[p] = 0;
      foreach (sb[i]) if (sb[i].hit && sb[i].due == e && sb[i].tgt == p) begin
        sb[i].hit = 0; sb[i].total = 0;
      end
    end
    ko_valid = 1'b1; ko_player = 3'(p);
    #1;
    n_checks++;
    if (aif.atk_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL atk_ready_during_ko: got %b want 0", aif.atk_ready);
    end
    tick();
    ko_valid = 1'b0; ko_player = 3'd0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (damage_bus !== '0 || invuln !== '0 || aif.last_damage !== '0) begin
      n_errors++;
      $display("FAIL reset_state: bus=%h inv=%b last=%0d want all zero", damage_bus, invuln, aif.last_damage);
    end
    n_checks++;
    if (aif.atk_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: got %b want 1", aif.atk_ready);
    end
    tick();
  endtask

  task automatic test_basic_hit();
    offer(32'h021, 1);
    n_checks++;
    if (invuln[1] !== 1'b1 || aif.hit_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_stage1: invuln1=%b ack=%b want 1/0", invuln[1], aif.hit_ack);
    end
    tick();
    n_checks++;
    if (dmg_of(1) != 5 || aif.last_damage !== 10'd5) begin
      n_errors++;
      $display("FAIL basic_result: cnt=%0d last=%0d want 5/5", dmg_of(1), aif.last_damage);
    end
    repeat (58) tick();
    n_checks++;
    if (invuln[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL invuln_window_end: got %b want 1", invuln[1]);
    end
    tick();
    n_checks++;
    if (invuln[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL invuln_expired: got %b want 0", invuln[1]);
    end
  endtask

  task automatic test_ko_wins();
    repeat (2) tick();
    offer(32'h021, 3);
    ko(3);
    n_checks++;
    if (dmg_of(3) != 0 || invuln[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL ko_wins: cnt=%0d inv=%b want 0/0", dmg_of(3), invuln[3]);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    offer(32'h041, 2);
    offer(32'h041, 2);
    repeat (2) tick();
    n_checks++;
    if (dmg_of(2) != 20) begin
      n_errors++;
      $display("FAIL b2b_same_target: cnt=%0d want 20", dmg_of(2));
    end
  endtask

  task automatic test_pipeline();
    offer(32'h401, 0);
    offer(32'h021, 3);
    repeat (3) tick();
  endtask

  task automatic test_drops();
    repeat (61) tick();
    offer(32'h021, 5);
    offer(32'h020, 1);
    offer(32'h7E0, 1);
    // Request while KO is active is never offered; out-of-range KO changes nothing
    ko_valid = 1'b1; ko_player = 3'd7;
    aif.atk_valid = 1'b1; aif.attack = 32'h021; aif.atk_target = 3'd1;
    tick();
    aif.atk_valid = 1'b0; ko_valid = 1'b0;
    repeat (2) tick();
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (dmg_of(p) != exp_dmg[p]) begin
        n_errors++;
        $display("FAIL counter_hold p%0d: got %0d want %0d", p, dmg_of(p), exp_dmg[p]);
      end
    end
  endtask

  task automatic test_saturation();
    ko(0);
    while (exp_dmg[0] < 970) begin
      offer(32'h101, 0);
      repeat (60) tick();
    end
    offer(32'h101, 0);
    repeat (2) tick();
    n_checks++;
    if (dmg_of(0) != 999) begin
      n_errors++;
      $display("FAIL saturate: cnt=%0d want 999", dmg_of(0));
    end
  endtask

  task automatic test_stale();
    int want2;
`ifdef DAMAGE_STALE_MOVES_EN
    want2 = 22;
`else
    want2 = 30;
`endif
    ko(1);
    offer(32'h081, 1);
    tick();
    n_checks++;
    if (dmg_of(1) != 15) begin
      n_errors++;
      $display("FAIL stale_first: cnt=%0d want 15", dmg_of(1));
    end
    repeat (59) tick();
    offer(32'h081, 1);
    repeat (2) tick();
    n_checks++;
    if (dmg_of(1) != want2) begin
      n_errors++;
      $display("FAIL stale_second: cnt=%0d want %0d", dmg_of(1), want2);
    end
  endtask

  task automatic test_reset_midflight();
    repeat (61) tick();
    aif.atk_valid = 1'b1; aif.attack = 32'h041; aif.atk_target = 3'd2;
    tick();
    aif.atk_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    model_clear();
    #1;
    n_checks++;
    if (damage_bus !== '0 || invuln !== '0) begin
      n_errors++;
      $display("FAIL async_reset: bus=%h inv=%b want 0", damage_bus, invuln);
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    reset = 1'b1; ko_valid = 1'b0; ko_player = 3'd0;
    aif.atk_valid = 1'b0; aif.attack = '0; aif.atk_target = 3'd0;
    repeat (2) @(posedge clock);
    reset = 1'b0;
    test_reset();
    test_basic_hit();
    test_ko_wins();
    test_back_to_back();
    test_pipeline();
    test_drops();
    test_saturation();
    test_stale();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
